// File: rtl/pipelined_adder_nbit_pkg.sv
// Shared constants and parameter helpers for pipelined_adder_nbit and its users.
package pipelined_adder_nbit_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 32;
  localparam int unsigned DEFAULT_STAGES = 4;

  function automatic bit stages_legal(input int unsigned width, input int unsigned stages);
    return (stages != 0) && ((width % stages) == 0);
  endfunction

  function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage

// File: rtl/pipelined_adder_nbit_chunk.sv
// adder_chunk: combinational CHUNK-bit ripple adder; c_msb exists only with PIPELINED_ADDER_OVF_EN.
module adder_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             c_msb
`endif
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
`ifdef PIPELINED_ADDER_OVF_EN
    c_msb = 1'b0;
`endif
    for (int unsigned i = 0; i < CHUNK; i++) begin
`ifdef PIPELINED_ADDER_OVF_EN
      if (i == CHUNK - 1) c_msb = carry;
`endif
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined WIDTH-bit adder, one CHUNK-bit slice of the carry chain per stage, valid/ready on both sides.
// Optional Overflow output enabled by PIPELINED_ADDER_OVF_EN.
module pipelined_adder_nbit
  import pipelined_adder_nbit_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if (!stages_legal(WIDTH, STAGES)) begin : g_illegal
    $error("pipelined_adder_nbit: STAGES must be nonzero and divide WIDTH");
  end

  logic [STAGES-1:0] v_q, c_q, v_d, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES:0]   rdy;

  // A stage may load when it is empty or the stage after it is moving; this lets bubbles collapse.
  always_comb begin
    rdy[STAGES] = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      rdy[STAGES-1-i] = !v_q[STAGES-1-i] || rdy[STAGES-i];
    end
  end

`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf_d, ovf_q;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, s_in, s_nxt;
    logic [CHUNK-1:0] cs;
    logic             c_in, v_in, co;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             msb;
`endif

    if (k == 0) begin : g_first
      assign a_in = A;
      assign b_in = B;
      assign s_in = '0;
      assign c_in = Cin;
      assign v_in = in_valid;
    end else begin : g_next
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign s_in = s_q[k-1];
      assign c_in = c_q[k-1];
      assign v_in = v_q[k-1];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (a_in[k*CHUNK +: CHUNK]),
      .b    (b_in[k*CHUNK +: CHUNK]),
      .cin  (c_in),
      .sum  (cs),
      .cout (co)
`ifdef PIPELINED_ADDER_OVF_EN
      ,
      .c_msb(msb)
`endif
    );

    always_comb begin
      s_nxt = s_in;
      s_nxt[k*CHUNK +: CHUNK] = cs;
    end

    assign v_d[k] = v_in;
    assign c_d[k] = co;
    assign a_d[k] = a_in;
    assign b_d[k] = b_in;
    assign s_d[k] = s_nxt;

`ifdef PIPELINED_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      assign ovf_d = co ^ msb;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
`ifdef PIPELINED_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          v_q[k] <= v_d[k];
          if (v_d[k]) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
            c_q[k] <= c_d[k];
          end
        end
      end
`ifdef PIPELINED_ADDER_OVF_EN
      if (rdy[STAGES-1] && v_d[STAGES-1]) ovf_q <= ovf_d;
`endif
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign Sum       = s_q[STAGES-1];
  assign Carry     = c_q[STAGES-1];
`ifdef PIPELINED_ADDER_OVF_EN
  assign Overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Self-checking bench for pipelined_adder_nbit (WIDTH=32, STAGES=4); Overflow checked when PIPELINED_ADDER_OVF_EN is defined.
module tb_pipelined_adder_nbit;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  logic         clk, rst_n, in_valid, in_ready, Cin, out_valid, out_ready, Carry;
  logic [W-1:0] A, B, Sum;
`ifdef PIPELINED_ADDER_OVF_EN
  logic         Overflow;
`endif

  pipelined_adder_nbit #(.WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Sum      (Sum),
    .Carry    (Carry)
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    .Overflow (Overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;
  logic [W+1:0] q [$];   // expected {ovf, carry, sum} in acceptance order
  bit           last_acc;
  int unsigned  acc_cnt;

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] t;
    logic       ovf;
    t   = a + b + c;
    ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {ovf, t};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One cycle: inputs were driven at the preceding negedge; record transfers, score outputs, advance.
  task automatic tick();
    logic [W+1:0] e;
    #1;
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
      else begin
        e = q.pop_front();
        chk("sb_sum", Sum, e[W-1:0]);
        chk("sb_carry", Carry, e[W]);
`ifdef PIPELINED_ADDER_OVF_EN
        chk("sb_ovf", Overflow, e[W+1]);
`endif
      end
    end
    if (last_acc) q.push_back(model(A, B, Cin));
    @(negedge clk);
  endtask

  task automatic drive_rand();
    A = $urandom;
    B = $urandom;
    Cin = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    chk(tag, q.size(), 0);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    A = a; B = b; Cin = c; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk({tag, "_accepted"}, last_acc, 1);
    in_valid = 1'b0;
    for (int i = 1; i <= int'(S); i++) begin
      chk({tag, "_latency"}, out_valid, (i == int'(S)) ? 1 : 0);
      if (i < int'(S)) tick();
    end
    chk({tag, "_sum"}, Sum, es);
    chk({tag, "_carry"}, Carry, ec);
`ifdef PIPELINED_ADDER_OVF_EN
    chk({tag, "_ovf"}, Overflow, eo);
`else
    if (eo === 1'bx) $display("unused");
`endif
    tick();
    chk({tag, "_consumed"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Cin = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_carry", Carry, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    directed("full_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    directed("stage_boundary", 32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0, 1'b0);
`ifdef PIPELINED_ADDER_OVF_EN
    directed("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    directed("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
`endif

    // Streaming, one op per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      #1 chk("stream_in_ready", in_ready, 1);
      tick();
      if (i >= int'(S)) chk("stream_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    drain("stream_drain");

    // Backpressure: fill, hold, then consume-and-accept on a full pipe
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive_rand();
      tick();
      if (last_acc) acc_cnt++;
    end
    chk("bp_accepted", acc_cnt, S);
    chk("bp_in_ready_full", in_ready, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", Sum, q[0][W-1:0]);
      chk("bp_hold_carry", Carry, q[0][W]);
    end
    out_ready = 1'b1;
    drive_rand();
    #1 chk("bp_full_accept_ready", in_ready, 1);
    tick();
    chk("bp_full_accept", last_acc, 1);
    in_valid = 1'b0;
    drain("bp_drain");
    chk("bp_in_ready_after", in_ready, 1);

    // Reset with operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("rf_out_valid_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rf_out_valid", out_valid, 0);
    chk("rf_sum", Sum, 0);
    chk("rf_carry", Carry, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rf_no_stale", out_valid, 0);
    end
    chk("rf_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
